// File: rtl/cpu_pkg.sv
// Shared constants and types for the interrupt controller: CSR addresses and FSM encoding.
package cpu_pkg;

  localparam logic [1:0] IRQ_CSR_MASK = 2'd0;
  localparam logic [1:0] IRQ_CSR_MODE = 2'd1;
  localparam logic [1:0] IRQ_CSR_PEND = 2'd2;
  localparam logic [1:0] IRQ_CSR_STAT = 2'd3;

  typedef enum logic [1:0] {
    StIdle    = 2'd0,
    StReq     = 2'd1,
    StService = 2'd2
  } irq_state_e;

endpackage

// File: rtl/irq_ctrl_if.sv
// CSR bus plus req/ack/EOI handshake between the datapath (master) and irq_ctrl (slave).
interface irq_ctrl_if #(
  parameter int unsigned N_SRC = 4,
  parameter int unsigned ID_W  = 4
);
  logic             csr_we;
  logic [1:0]       csr_addr;
  logic [N_SRC-1:0] csr_wdata;
  logic [15:0]      csr_rdata;
  logic             irq_req;
  logic             irq_ack;
  logic [ID_W-1:0]  irq_id;
  logic [31:0]      irq_target;
  logic             irq_eoi;

  modport master (
    output csr_we, csr_addr, csr_wdata, irq_ack, irq_eoi,
    input  csr_rdata, irq_req, irq_id, irq_target
  );

  modport slave (
    input  csr_we, csr_addr, csr_wdata, irq_ack, irq_eoi,
    output csr_rdata, irq_req, irq_id, irq_target
  );
endinterface

// File: rtl/intr_sync.sv
// Per-bit multi-stage synchroniser for asynchronous request pins, with a rising-edge detector.
module intr_sync #(
  parameter int unsigned WIDTH  = 4,
  parameter int unsigned STAGES = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] intr_i,
  output logic [WIDTH-1:0] level_o,
  output logic [WIDTH-1:0] rise_o
);

  logic [STAGES-1:0][WIDTH-1:0] stage_q;
  logic [WIDTH-1:0]             prev_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      stage_q <= '0;
      prev_q  <= '0;
    end else begin
      stage_q[0] <= intr_i;
      for (int i = 1; i < int'(STAGES); i++) begin
        stage_q[i] <= stage_q[i-1];
      end
      prev_q <= stage_q[STAGES-1];
    end
  end

  assign level_o = stage_q[STAGES-1];
  assign rise_o  = stage_q[STAGES-1] & ~prev_q;

endmodule

// File: rtl/irq_ctrl.sv
// Multi-source interrupt controller: synchronised edge/level sources, mask, fixed priority
// (lowest index wins) and a single-level req/ack/EOI handshake to the datapath.
module irq_ctrl
  import cpu_pkg::*;
#(
  parameter int unsigned N_SRC       = 4,
  parameter int unsigned SYNC_STAGES = 2,
  parameter logic [31:0] VEC_BASE    = 32'h0000_0100,
  parameter logic [31:0] VEC_STRIDE  = 32'h0000_0010,
  parameter int unsigned ID_W        = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_SRC-1:0] intr,
  irq_ctrl_if.slave        bus
);

  logic [N_SRC-1:0] level, rise;
  logic [N_SRC-1:0] mask_q, mask_d, mode_q, mode_d, pend_q, pend_d;
  logic [N_SRC-1:0] eligible, w1c;
  logic             ack_clr, clr;
  logic [ID_W-1:0]  win_id, id_q;
  logic [31:0]      win_target, target_q;
  logic             req_q;
  irq_state_e       state_q;

  intr_sync #(
    .WIDTH  (N_SRC),
    .STAGES (SYNC_STAGES)
  ) u_sync (
    .clk     (clk),
    .reset   (reset),
    .intr_i  (intr),
    .level_o (level),
    .rise_o  (rise)
  );

  assign eligible = pend_q & mask_q;

  // Scan downwards so the lowest eligible index is the last assignment.
  always_comb begin
    win_id = '0;
    for (int i = int'(N_SRC) - 1; i >= 0; i--) begin
      if (eligible[i]) win_id = ID_W'(i);
    end
    win_target = VEC_BASE + 32'(win_id) * VEC_STRIDE;
  end

  always_comb begin
    mask_d  = mask_q;
    mode_d  = mode_q;
    w1c     = '0;
    ack_clr = (state_q == StReq) && bus.irq_ack;
    if (bus.csr_we) begin
      if (bus.csr_addr == IRQ_CSR_MASK) mask_d = bus.csr_wdata;
      if (bus.csr_addr == IRQ_CSR_MODE) mode_d = bus.csr_wdata;
      if (bus.csr_addr == IRQ_CSR_PEND) w1c    = bus.csr_wdata;
    end
    pend_d = '0;
    clr    = 1'b0;
    for (int i = 0; i < int'(N_SRC); i++) begin
      if (mode_q[i]) begin
        // A fresh rising edge beats any clear arriving in the same cycle.
        clr       = w1c[i] | (ack_clr && (id_q == ID_W'(i)));
        pend_d[i] = rise[i] | (pend_q[i] & ~clr);
      end else begin
        pend_d[i] = level[i];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      mask_q <= '0;
      mode_q <= '1;
      pend_q <= '0;
    end else begin
      mask_q <= mask_d;
      mode_q <= mode_d;
      pend_q <= pend_d;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= StIdle;
      req_q    <= 1'b0;
      id_q     <= '0;
      target_q <= VEC_BASE;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (|eligible) begin
            state_q  <= StReq;
            req_q    <= 1'b1;
            id_q     <= win_id;
            target_q <= win_target;
          end
        end
        StReq: begin
          if (bus.irq_ack) begin
            state_q <= StService;
            req_q   <= 1'b0;
          end else if (!mask_q[id_q]) begin
            state_q <= StIdle;
            req_q   <= 1'b0;
          end
        end
        StService: begin
          if (bus.irq_eoi) state_q <= StIdle;
        end
        default: begin
          state_q <= StIdle;
          req_q   <= 1'b0;
        end
      endcase
    end
  end

  always_comb begin
    bus.csr_rdata = '0;
    unique case (bus.csr_addr)
      IRQ_CSR_MASK: bus.csr_rdata[N_SRC-1:0] = mask_q;
      IRQ_CSR_MODE: bus.csr_rdata[N_SRC-1:0] = mode_q;
      IRQ_CSR_PEND: bus.csr_rdata[N_SRC-1:0] = pend_q;
      IRQ_CSR_STAT: begin
        bus.csr_rdata[9:8]      = state_q;
        bus.csr_rdata[ID_W-1:0] = id_q;
      end
      default: bus.csr_rdata = '0;
    endcase
  end

  assign bus.irq_req    = req_q;
  assign bus.irq_id     = id_q;
  assign bus.irq_target = target_q;

endmodule

// File: doc/irq_ctrl.md
Name: irq_ctrl

Overview:
- Parametrised successor to the single `intr` line feeding the datapath: a multi-source interrupt controller.
- Takes N_SRC asynchronous request pins and synchronises them.
- Per-channel: edge or level mode, maskable, fixed priority.
- Presents one request plus a vector target PC to the datapath via a req/ack/EOI handshake.
- Sits beside the datapath, clocked by the PLL-divided CPU clock.

Parameters:
- N_SRC, 4, number of interrupt sources (1..16).
- SYNC_STAGES, 2, synchroniser flops per source (>=2).
- VEC_BASE, 32'h0000_0100, target PC of source 0.
- VEC_STRIDE, 32'h0000_0010, byte spacing between consecutive source targets.
- ID_W, 4, width of source index (>= clog2(N_SRC)).

Ports:
- clk, in, 1, CPU clock (divided clock).
- reset, in, 1, synchronous active-high reset.
- intr, in, N_SRC, asynchronous raw requests.
- csr_we, in, 1, CSR write strobe.
- csr_addr, in, 2, CSR select.
- csr_wdata, in, N_SRC, CSR write data.
- csr_rdata, out, 16, CSR read data (combinational, zero-extended).
- irq_req, out, 1, request to datapath.
- irq_ack, in, 1, one-cycle pulse: datapath takes the interrupt.
- irq_id, out, ID_W, index of latched source.
- irq_target, out, 32, VEC_BASE + irq_id*VEC_STRIDE.
- irq_eoi, in, 1, one-cycle pulse: handler finished.

Behaviour:
- One clock `clk`; reset is synchronous, active-high. All state updates on the rising edge of clk.
- Reset values:
  - mask = 0 (all disabled); mode = all 1 (edge).
  - pending = 0; sync/prev flops = 0; state = IDLE.
  - irq_req = 0; irq_id = 0; irq_target = VEC_BASE.
- Reset mid-handshake returns to IDLE and drops irq_req in the same edge.
- Synchroniser: each intr bit passes through SYNC_STAGES flops; s = last stage.
- Edge mode: the rising-edge term s & ~prev sets the pending bit.
- Level mode: the pending bit equals s each cycle. Ack does not clear it; it stays asserted until the source deasserts.
- Latency (edge mode): intr rising before edge k gives pending=1 after edge k+SYNC_STAGES and irq_req=1 after edge k+SYNC_STAGES+1, provided the source is unmasked and the controller is in IDLE.
- Eligible = pending & mask. Priority: lowest index wins.
- CSR map:
  - 0 mask, RW.
  - 1 mode, RW (1 = edge, 0 = level).
  - 2 pending: R; write-1-to-clear, affects edge-mode bits only.
  - 3 status, R: {state[1:0] in bits 9:8, irq_id in bits ID_W-1:0}.
- CSR writes take effect at the next edge.
- FSM transitions:
  - IDLE: if eligible != 0, latch irq_id = highest-priority index → REQ (irq_req=1 registered).
  - REQ: irq_req=1; irq_id and irq_target are held stable, with no preemption by higher sources.
    - irq_ack → SERVICE, irq_req=0; clear pending[irq_id] if that source is edge mode.
    - Source masked while in REQ (mask bit cleared) → IDLE, irq_req=0, pending kept.
  - SERVICE: irq_req=0; new pending bits accumulate. irq_eoi → IDLE.
- Other inputs outside their state: irq_ack outside REQ is ignored; irq_eoi outside SERVICE is ignored.
- Simultaneous events:
  - New rising edge on the same source as ack-clear or W1C in the same cycle: set wins, pending stays 1.
  - Mask write and eligibility evaluation in the same cycle: the old mask is used.
- No nesting; a single in-service level only.
- irq_target arithmetic: 32-bit, wraps modulo 2^32.

Decomposition:
- Package cpu_pkg:
  - CSR address constants IRQ_CSR_MASK=0, IRQ_CSR_MODE=1, IRQ_CSR_PEND=2, IRQ_CSR_STAT=3.
  - FSM state encoding IDLE=0, REQ=1, SERVICE=2.
- Sub-module intr_sync: per-bit N-stage synchroniser plus prev flop. Outputs the synced level and the rising pulse; instantiated once with width N_SRC.
- Priority encoder and FSM live in irq_ctrl.

Test Plan:
- Reset, then read CSRs 0..3 → 0x0000, 0x000F, 0x0000, 0x0000; irq_req=0.
- Mask=0x4, pulse intr[2] for 1 cycle → irq_req high exactly SYNC_STAGES+2 edges later. irq_id=2, irq_target=0x120. Ack → pending reads 0x0, state SERVICE. Eoi → IDLE.
- Mask=0xF, intr[3] and intr[1] rise same cycle → irq_id=1 first. After ack+eoi, irq_id=3 with target 0x130.
- Level mode: mode=0x0, mask=0x1, hold intr[0]=1 → ack+eoi re-requests immediately. Drop intr[0] → pending 0, no further request.
- In REQ for source 2, write mask=0x0 → irq_req falls next edge, pending[2] still 1. Write 0x4 to CSR 2 → pending 0.
- Assert reset while in SERVICE → state IDLE and irq_req=0 after one edge; irq_eoi, and irq_ack while not in REQ, are ignored.
